vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing generator that sits directly upstream of VGA_control's colour stage.
//  - Divides the system clock into a pixel-enable tick.
//  - Runs the horizontal and vertical raster counters.
//  - Drives HS/VS plus pixel coordinates and an active-video flag, so the colour
//    logic only maps (X,Y,ACTIVE) to R/G/B.
//  - Default timing is 640x480@60 Hz from a 100 MHz CLK (25 MHz pixel rate).
// PARAMETERS
//  CLK_DIV   4    CLK cycles per pixel (>=1); PIX_EN asserted 1 cycle in CLK_DIV
//  H_VIS     640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   horizontal sync width (pixels)
//  H_BP      48   horizontal back porch (pixels); H_TOTAL=H_VIS+H_FP+H_SYNC+H_BP=800
//  V_VIS     480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vertical sync width (lines)
//  V_BP      33   vertical back porch (lines); V_TOTAL=525
//  SYNC_POL  0    sync active level (0 = active-low, per 640x480 standard)
// PORTS
//  CLK          in   1   system clock, all logic on rising edge
//  RST          in   1   synchronous, active-high reset
//  PIX_EN       out  1   pixel tick, high for 1 CLK when pixel state advances
//  X            out  10  horizontal counter value, 0..H_TOTAL-1
//  Y            out  10  vertical counter value, 0..V_TOTAL-1
//  ACTIVE       out  1   high when X<H_VIS and Y<V_VIS
//  HS           out  1   horizontal sync (level per SYNC_POL)
//  VS           out  1   vertical sync (level per SYNC_POL)
//  LINE_START   out  1   1-CLK pulse coincident with the tick that sets X to 0
//  FRAME_START  out  1   1-CLK pulse coincident with the tick that sets X=0,Y=0
// BEHAVIOUR
//  - Reset (RST high at a CLK edge):
//    - div=0, X=0, Y=0, PIX_EN=0, LINE_START=0, FRAME_START=0, ACTIVE=0.
//    - HS and VS at their inactive level (~SYNC_POL).
//    - RST overrides everything, including mid-line or mid-frame.
//  - Divider counts 0..CLK_DIV-1 and wraps.
//    - PIX_EN is registered: high in the CLK cycle after div==CLK_DIV-1.
//    - First PIX_EN after reset release is CLK_DIV cycles later.
//    - CLK_DIV=1: PIX_EN is constantly high after the first cycle out of reset.
//  - On each PIX_EN cycle's edge: X=X+1.
//    - X==H_TOTAL-1 wraps X to 0 and advances Y.
//    - Y==V_TOTAL-1 at the wrap also wraps Y to 0.
//    - Counters never exceed *_TOTAL-1.
//  - All outputs are registered and decoded from the next-state counters, so
//    X, Y, ACTIVE, HS and VS change on the same CLK edge (zero skew between them).
//  - Decode:
//    - HS = SYNC_POL while H_VIS+H_FP <= X < H_VIS+H_FP+H_SYNC, else ~SYNC_POL.
//    - VS uses the same rule on Y with the V_* values.
//  - LINE_START and FRAME_START are asserted on the edge where the counters
//    load X=0 (and Y=0 for FRAME_START). They deassert on the next CLK edge.
//  - Width rules:
//    - 10-bit counters; H_TOTAL and V_TOTAL must be <=1024.
//    - Comparisons are unsigned; no sum is allowed to overflow 11 bits.
// STRUCTURE
//  - Timing constants (640x480 defaults, derived H_TOTAL/V_TOTAL, sync start/end)
//    go in shared include vga_params.vh. VGA_control and later VGA stages use the same file.
//  - One sub-module: pix_tick_gen (CLK, RST -> PIX_EN, parameter CLK_DIV).
//  - Counters and decode stay in vga_timing_gen.
// TESTING
//  1. Reset and first tick:
//     - Hold RST 5 cycles, then release.
//     - HS=VS=1, ACTIVE=0, X=Y=0 during reset.
//     - First PIX_EN exactly 4 CLK after release.
//  2. Line timing:
//     - PIX_EN period is 4 CLK.
//     - HS low for exactly 384 CLK, starting when X becomes 656.
//     - LINE_START pulses every 3200 CLK.
//     - ACTIVE high for 640 ticks per visible line.
//  3. Frame timing:
//     - FRAME_START period is 1,680,000 CLK.
//     - VS low for exactly 2 lines (6400 CLK), starting when Y becomes 490.
//     - ACTIVE never high for Y>=480.
//  4. Wrap corner:
//     - At X=799,Y=524 the next tick gives X=0,Y=0.
//     - FRAME_START and LINE_START both pulse; ACTIVE rises in the same cycle.
//  5. Mid-frame reset:
//     - Assert RST at X=700,Y=300 for 1 CLK.
//     - Next cycle: X=Y=0, HS=VS=1, PIX_EN=0.
//     - Timing then resumes as in test 1.
//  6. CLK_DIV=1 build:
//     - PIX_EN high every cycle after reset release.
//     - Line period 800 CLK, HS width 96 CLK.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared raster timing constants, bus payload types and decode helper for the VGA pipeline.
// VGA_control and the later colour stages import the same definitions.
package vga_timing_gen_pkg;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned SUM_W = CNT_W + 1;

  // 640x480@60 Hz from a 100 MHz system clock
  localparam int unsigned DEF_CLK_DIV = 4;
  localparam int unsigned DEF_H_VIS   = 640;
  localparam int unsigned DEF_H_FP    = 16;
  localparam int unsigned DEF_H_SYNC  = 96;
  localparam int unsigned DEF_H_BP    = 48;
  localparam int unsigned DEF_V_VIS   = 480;
  localparam int unsigned DEF_V_FP    = 10;
  localparam int unsigned DEF_V_SYNC  = 2;
  localparam int unsigned DEF_V_BP    = 33;
  localparam logic        DEF_SYNC_POL = 1'b0;

  typedef struct packed {
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } raster_pos_t;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic line_start;
    logic frame_start;
  } raster_flags_t;

  // Half-open window test lo <= v < hi on zero-extended counter values
  function automatic logic in_window(input logic [SUM_W-1:0] v,
                                     input logic [SUM_W-1:0] lo,
                                     input logic [SUM_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_pix_tick.sv
// Pixel-rate tick generator: one registered pix_en pulse every CLK_DIV system clocks.
module pix_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  // pix_en lands one cycle after the divider reaches its last count
  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      pix_en <= (div == DIV_LAST);
      div    <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel tick, H/V counters and registered sync/active/start decode.
// Every output is registered from the next-state counters so x, y and the decodes move together.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_VIS    = DEF_H_VIS,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_VIS    = DEF_V_VIS,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_POL = DEF_SYNC_POL
) (
  input  logic             clk,
  input  logic             rst,
  output logic             pix_en,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             active,
  output logic             hs,
  output logic             vs,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [SUM_W-1:0] H_VIS_L = SUM_W'(H_VIS);
  localparam logic [SUM_W-1:0] V_VIS_L = SUM_W'(V_VIS);
  localparam logic [SUM_W-1:0] HS_BEG  = SUM_W'(H_VIS + H_FP);
  localparam logic [SUM_W-1:0] HS_END  = SUM_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [SUM_W-1:0] VS_BEG  = SUM_W'(V_VIS + V_FP);
  localparam logic [SUM_W-1:0] VS_END  = SUM_W'(V_VIS + V_FP + V_SYNC);

  localparam raster_flags_t RST_FLAGS = '{
    active:      1'b0,
    hs:          ~SYNC_POL,
    vs:          ~SYNC_POL,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  raster_pos_t      pos_q;
  raster_pos_t      pos_d;
  raster_flags_t    flags_q;
  raster_flags_t    flags_d;
  logic             wrap_line;
  logic             wrap_frame;
  logic [SUM_W-1:0] x_ext;
  logic [SUM_W-1:0] y_ext;

  pix_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );

  // Raster advance; >= keeps the counters bounded even from an unexpected value
  always_comb begin
    pos_d      = pos_q;
    wrap_line  = 1'b0;
    wrap_frame = 1'b0;
    if (pix_en) begin
      if (pos_q.x >= H_LAST) begin
        pos_d.x   = '0;
        wrap_line = 1'b1;
        if (pos_q.y >= V_LAST) begin
          pos_d.y    = '0;
          wrap_frame = 1'b1;
        end else begin
          pos_d.y = pos_q.y + CNT_W'(1);
        end
      end else begin
        pos_d.x = pos_q.x + CNT_W'(1);
      end
    end
  end

  // Decode from the next-state position so the registered flags align with x/y
  always_comb begin
    flags_d             = '0;
    x_ext               = {1'b0, pos_d.x};
    y_ext               = {1'b0, pos_d.y};
    flags_d.active      = (x_ext < H_VIS_L) && (y_ext < V_VIS_L);
    flags_d.hs          = in_window(x_ext, HS_BEG, HS_END) ? SYNC_POL : ~SYNC_POL;
    flags_d.vs          = in_window(y_ext, VS_BEG, VS_END) ? SYNC_POL : ~SYNC_POL;
    flags_d.line_start  = wrap_line;
    flags_d.frame_start = wrap_frame;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q   <= '0;
      flags_q <= RST_FLAGS;
    end else begin
      pos_q   <= pos_d;
      flags_q <= flags_d;
    end
  end

  assign x           = pos_q.x;
  assign y           = pos_q.y;
  assign active      = flags_q.active;
  assign hs          = flags_q.hs;
  assign vs          = flags_q.vs;
  assign line_start  = flags_q.line_start;
  assign frame_start = flags_q.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, reduced-size (active-high sync) and CLK_DIV=1 builds
// compared every cycle against an arithmetic raster model, plus directed timing checks.
module tb_vga_timing_gen;

  typedef struct {
    int   div;
    int   hv, hfp, hsy, hbp;
    int   vv, vfp, vsy, vbp;
    logic pol;
  } cfg_t;

  typedef struct packed {
    logic       pe;
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } obs_t;

  typedef struct {
    int   k;
    int   x;
    int   y;
    logic pe;
    logic act;
    logic hs;
    logic ls;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  int   k_a = 0, k_b = 0, k_c = 0;

  logic       a_pe, a_act, a_hs, a_vs, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_pe, b_act, b_hs, b_vs, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic       c_pe, c_act, c_hs, c_vs, c_ls, c_fs;
  logic [9:0] c_x, c_y;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  cfg_t cfg[3];
  obs_t cur[3];
  int   last_ls[3], ls_period[3], last_fs[3], fs_period[3];
  int   act_cnt[3], act_line[3], bad_act[3];
  int   hs_start[3], hs_width[3], hs_pos[3];
  int   vs_start[3], vs_width[3], vs_pos[3];
  bit   p_ls[3], p_fs[3], p_hs[3], p_vs[3];
  int   hold[3];
  vec_t tbl[13];

  always #5 clk = ~clk;

  vga_timing_gen u_a (
    .clk(clk), .rst(rst_a), .pix_en(a_pe), .x(a_x), .y(a_y), .active(a_act),
    .hs(a_hs), .vs(a_vs), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(5), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
  ) u_b (
    .clk(clk), .rst(rst_b), .pix_en(b_pe), .x(b_x), .y(b_y), .active(b_act),
    .hs(b_hs), .vs(b_vs), .line_start(b_ls), .frame_start(b_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(1)
  ) u_c (
    .clk(clk), .rst(rst_c), .pix_en(c_pe), .x(c_x), .y(c_y), .active(c_act),
    .hs(c_hs), .vs(c_vs), .line_start(c_ls), .frame_start(c_fs)
  );

  // Clock edges since the last reset edge, per build
  always @(posedge clk) begin
    k_a <= rst_a ? 0 : k_a + 1;
    k_b <= rst_b ? 0 : k_b + 1;
    k_c <= rst_c ? 0 : k_c + 1;
  end

  // Reference: pixel index is the number of completed ticks; position is plain div/mod
  function automatic obs_t model(cfg_t c, int k);
    obs_t o;
    int ht, vt, p, pp, px, py;
    o = '0;
    if (k == 0) begin
      o.hs = ~c.pol;
      o.vs = ~c.pol;
      return o;
    end
    ht = c.hv + c.hfp + c.hsy + c.hbp;
    vt = c.vv + c.vfp + c.vsy + c.vbp;
    p  = (k - 1) / c.div;
    pp = (k >= 2) ? (k - 2) / c.div : 0;
    px = p % ht;
    py = (p / ht) % vt;
    o.pe  = (k % c.div) == 0;
    o.x   = 10'(px);
    o.y   = 10'(py);
    o.act = (px < c.hv) && (py < c.vv);
    o.hs  = (px >= c.hv + c.hfp && px < c.hv + c.hfp + c.hsy) ? c.pol : ~c.pol;
    o.vs  = (py >= c.vv + c.vfp && py < c.vv + c.vfp + c.vsy) ? c.pol : ~c.pol;
    o.ls  = (p != pp) && (px == 0);
    o.fs  = o.ls && (py == 0);
    return o;
  endfunction

  function automatic obs_t get_obs(int i);
    case (i)
      0:       return {a_pe, a_x, a_y, a_act, a_hs, a_vs, a_ls, a_fs};
      1:       return {b_pe, b_x, b_y, b_act, b_hs, b_vs, b_ls, b_fs};
      default: return {c_pe, c_x, c_y, c_act, c_hs, c_vs, c_ls, c_fs};
    endcase
  endfunction

  function automatic int get_k(int i);
    case (i)
      0:       return k_a;
      1:       return k_b;
      default: return k_c;
    endcase
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("pe=%b x=%0d y=%0d act=%b hs=%b vs=%b ls=%b fs=%b",
                     o.pe, o.x, o.y, o.act, o.hs, o.vs, o.ls, o.fs);
  endfunction

  task automatic chk_int(string name, int got, int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      obs_t o;
      obs_t e;
      bit   hs_as, vs_as;
      o = get_obs(i);
      e = model(cfg[i], get_k(i));
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL model_%0d cyc=%0d k=%0d got %s expected %s",
                 i, cyc, get_k(i), fmt(o), fmt(e));
      end
      if (o.ls === 1'b1 && !p_ls[i]) begin
        if (last_ls[i] >= 0) ls_period[i] = cyc - last_ls[i];
        last_ls[i] = cyc;
        if (act_cnt[i] > 0) act_line[i] = act_cnt[i];
        act_cnt[i] = 0;
      end
      if (o.fs === 1'b1 && !p_fs[i]) begin
        if (last_fs[i] >= 0) fs_period[i] = cyc - last_fs[i];
        last_fs[i] = cyc;
      end
      if (o.act === 1'b1) begin
        act_cnt[i]++;
        if (int'(o.y) >= cfg[i].vv) bad_act[i]++;
      end
      hs_as = (o.hs === cfg[i].pol);
      vs_as = (o.vs === cfg[i].pol);
      if (hs_as && !p_hs[i]) begin hs_start[i] = cyc; hs_pos[i] = int'(o.x); end
      if (!hs_as && p_hs[i]) hs_width[i] = cyc - hs_start[i];
      if (vs_as && !p_vs[i]) begin vs_start[i] = cyc; vs_pos[i] = int'(o.y); end
      if (!vs_as && p_vs[i]) vs_width[i] = cyc - vs_start[i];
      p_ls[i] = (o.ls === 1'b1);
      p_fs[i] = (o.fs === 1'b1);
      p_hs[i] = hs_as;
      p_vs[i] = vs_as;
      cur[i]  = o;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    cfg[0] = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    cfg[1] = '{3, 8, 2, 3, 3, 5, 2, 2, 2, 1'b1};
    cfg[2] = '{1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    for (int i = 0; i < 3; i++) begin
      last_ls[i] = -1; last_fs[i] = -1; ls_period[i] = 0; fs_period[i] = 0;
      act_cnt[i] = 0; act_line[i] = 0; bad_act[i] = 0; hold[i] = 0;
      hs_start[i] = 0; hs_width[i] = 0; hs_pos[i] = -1;
      vs_start[i] = 0; vs_width[i] = 0; vs_pos[i] = -1;
    end

    // Default-build expectations: k = clock edges after reset release
    tbl[0]  = '{0,    0,   0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{3,    0,   0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{4,    0,   0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{5,    1,   0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{8,    1,   0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{2557, 639, 0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{2561, 640, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{2624, 655, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{2625, 656, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{3008, 751, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{3009, 752, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{3201, 0,   1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{3202, 0,   1, 1'b0, 1'b1, 1'b1, 1'b0};

    repeat (5) step();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    for (int i = 0; i < 13; i++) begin
      while (k_a < tbl[i].k) step();
      chk_int($sformatf("tbl%0d_x", i),   int'(cur[0].x), tbl[i].x);
      chk_int($sformatf("tbl%0d_y", i),   int'(cur[0].y), tbl[i].y);
      chk_int($sformatf("tbl%0d_pe", i),  int'(cur[0].pe), int'(tbl[i].pe));
      chk_int($sformatf("tbl%0d_act", i), int'(cur[0].act), int'(tbl[i].act));
      chk_int($sformatf("tbl%0d_hs", i),  int'(cur[0].hs), int'(tbl[i].hs));
      chk_int($sformatf("tbl%0d_vs", i),  int'(cur[0].vs), 1);
      chk_int($sformatf("tbl%0d_ls", i),  int'(cur[0].ls), int'(tbl[i].ls));
    end
    while (k_a < 6600) step();

    chk_int("a_line_period", ls_period[0], 3200);
    chk_int("a_active_per_line", act_line[0], 2560);
    chk_int("a_hs_width", hs_width[0], 384);
    chk_int("a_hs_start_x", hs_pos[0], 656);
    chk_int("b_line_period", ls_period[1], 48);
    chk_int("b_frame_period", fs_period[1], 528);
    chk_int("b_active_per_line", act_line[1], 24);
    chk_int("b_hs_width", hs_width[1], 9);
    chk_int("b_hs_start_x", hs_pos[1], 10);
    chk_int("b_vs_width", vs_width[1], 96);
    chk_int("b_vs_start_y", vs_pos[1], 7);
    chk_int("c_line_period", ls_period[2], 800);
    chk_int("c_active_per_line", act_line[2], 640);
    chk_int("c_hs_width", hs_width[2], 96);
    chk_int("c_hs_start_x", hs_pos[2], 656);
    for (int i = 0; i < 3; i++) chk_int($sformatf("blank_active_%0d", i), bad_act[i], 0);

    // Frame wrap corner on the reduced build
    n = 0;
    while (!(cur[1].x == 10'd15 && cur[1].y == 10'd10) && n < 1000) begin step(); n++; end
    chk_int("b_reach_corner", int'(cur[1].x == 10'd15 && cur[1].y == 10'd10), 1);
    n = 0;
    while (cur[1].fs !== 1'b1 && n < 8) begin step(); n++; end
    chk_int("b_wrap_x", int'(cur[1].x), 0);
    chk_int("b_wrap_y", int'(cur[1].y), 0);
    chk_int("b_wrap_ls", int'(cur[1].ls), 1);
    chk_int("b_wrap_fs", int'(cur[1].fs), 1);
    chk_int("b_wrap_act", int'(cur[1].act), 1);
    step();
    chk_int("b_wrap_fs_drop", int'(cur[1].fs), 0);
    chk_int("b_wrap_ls_drop", int'(cur[1].ls), 0);

    // Mid-line reset inside horizontal sync, default build
    n = 0;
    while (cur[0].x != 10'd700 && n < 4000) begin step(); n++; end
    chk_int("a_reach_x700", int'(cur[0].x), 700);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    chk_int("a_rst_x", int'(cur[0].x), 0);
    chk_int("a_rst_y", int'(cur[0].y), 0);
    chk_int("a_rst_hs", int'(cur[0].hs), 1);
    chk_int("a_rst_vs", int'(cur[0].vs), 1);
    chk_int("a_rst_pe", int'(cur[0].pe), 0);
    n = 0;
    while (cur[0].pe !== 1'b1 && n < 10) begin step(); n++; end
    chk_int("a_first_tick_after_rst", n, 4);

    // Mid-frame reset inside hsync of a visible line, reduced build
    n = 0;
    while (!(cur[1].x == 10'd11 && cur[1].y == 10'd3) && n < 1000) begin step(); n++; end
    chk_int("b_reach_mid", int'(cur[1].x == 10'd11 && cur[1].y == 10'd3), 1);
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    chk_int("b_rst_x", int'(cur[1].x), 0);
    chk_int("b_rst_y", int'(cur[1].y), 0);
    chk_int("b_rst_hs", int'(cur[1].hs), 0);
    chk_int("b_rst_vs", int'(cur[1].vs), 0);
    chk_int("b_rst_pe", int'(cur[1].pe), 0);
    n = 0;
    while (cur[1].pe !== 1'b1 && n < 10) begin step(); n++; end
    chk_int("b_first_tick_after_rst", n, 3);

    // Random reset pulses of random length on every build
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i] > 0) hold[i]--;
        else if ($urandom_range(0, 149) == 0) hold[i] = int'($urandom_range(1, 4));
      end
      rst_a = (hold[0] > 0);
      rst_b = (hold[1] > 0);
      rst_c = (hold[2] > 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
